// File: rtl/msi_irq_gen_if.sv
// PCIe core MSI request/grant handshake between the interrupt generator
// (master) and the endpoint configuration interface (slave).
interface msi_irq_gen_if;
  logic       cfg_interrupt_msienable;
  logic       cfg_interrupt_rdy_n;
  logic       cfg_interrupt_n;
  logic [7:0] cfg_interrupt_di;

  modport master (
    input  cfg_interrupt_msienable,
    input  cfg_interrupt_rdy_n,
    output cfg_interrupt_n,
    output cfg_interrupt_di
  );

  modport slave (
    output cfg_interrupt_msienable,
    output cfg_interrupt_rdy_n,
    input  cfg_interrupt_n,
    input  cfg_interrupt_di
  );
endinterface

// File: rtl/msi_irq_gen.sv
// MSI interrupt generator with coalescing. Host-visible events are counted
// into a saturating pending counter; a request is raised after a hold-off
// window or once enough events have piled up, held until the core grants
// it, and followed by a minimum idle gap before the next request.
module msi_irq_gen #(
  parameter logic [15:0] COALESCE_CYCLES = 16'd1000,
  parameter logic [15:0] BATCH_SIZE      = 16'd32,
  parameter logic [15:0] GAP_CYCLES      = 16'd16
) (
  input  logic               trn_clk,
  input  logic               reset_n,
  input  logic               interrupts_enabled,
  input  logic               irq_event,
  msi_irq_gen_if.master      cfg,
  output logic               irq_pending,
  output logic [31:0]        irq_count
);

  typedef enum logic [1:0] {IDLE, COAL, REQ, GAP} state_t;

  state_t      state, state_nxt;
  logic [15:0] pending, pending_nxt;
  logic [15:0] coal_tmr, coal_nxt;
  logic [15:0] gap_tmr, gap_nxt;
  logic [31:0] count_nxt;
  logic [15:0] pending_inc;
  logic        irq_allowed;
  logic        req_n;

  assign cfg.cfg_interrupt_di = 8'h00;
  assign cfg.cfg_interrupt_n  = req_n;

  // Next-state, counters and timers; events are counted in every state.
  always_comb begin
    state_nxt   = state;
    coal_nxt    = coal_tmr;
    gap_nxt     = gap_tmr;
    count_nxt   = irq_count;
    irq_allowed = interrupts_enabled && cfg.cfg_interrupt_msienable;
    pending_inc = (pending == 16'hFFFF) ? pending : pending + 16'd1;
    pending_nxt = irq_event ? pending_inc : pending;

    case (state)
      IDLE: begin
        if (pending != 16'd0 && irq_allowed) begin
          state_nxt = COAL;
          coal_nxt  = 16'd0;
        end
      end
      COAL: begin
        coal_nxt = coal_tmr + 16'd1;
        if (!irq_allowed)
          state_nxt = IDLE;
        else if (coal_tmr == COALESCE_CYCLES - 16'd1 || pending >= BATCH_SIZE)
          state_nxt = REQ;
      end
      REQ: begin
        // Request is never withdrawn: only the grant moves us on.
        if (!cfg.cfg_interrupt_rdy_n) begin
          count_nxt   = irq_count + 32'd1;
          pending_nxt = {15'd0, irq_event};
          gap_nxt     = 16'd0;
          state_nxt   = (GAP_CYCLES == 16'd0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_nxt = gap_tmr + 16'd1;
        if (gap_tmr == GAP_CYCLES - 16'd1)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset is synchronous.
  always_ff @(posedge trn_clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pending     <= 16'd0;
      coal_tmr    <= 16'd0;
      gap_tmr     <= 16'd0;
      irq_count   <= 32'd0;
      req_n       <= 1'b1;
      irq_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      coal_tmr    <= coal_nxt;
      gap_tmr     <= gap_nxt;
      irq_count   <= count_nxt;
      req_n       <= (state_nxt != REQ);
      irq_pending <= (pending_nxt != 16'd0);
    end
  end

endmodule
